// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states and the forwarding-priority helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // MEM is the younger producer so it wins over WB; x0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] rs
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage RV core: stage enables/flushes, EXE
// forwarding selects, drain-then-halt on ecall and performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic             ex_branch_taken,
    input  logic             ex_ecall_halt,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_reg_write,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               load_use;
    logic               run_halt;
    logic               run_branch;
    logic               run_stall;

    assign load_use = ex_mem_to_reg && ex_reg_write && (ex_rd_addr != 5'd0) &&
                      ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                       (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    // RUN-state priority: halt, then branch (wrong-path load-use dropped), then stall.
    assign run_halt   = (state == ST_RUN) && ex_ecall_halt;
    assign run_branch = (state == ST_RUN) && !ex_ecall_halt && ex_branch_taken;
    assign run_stall  = (state == ST_RUN) && !ex_ecall_halt && !ex_branch_taken && load_use;

    assign fwd_a     = fwd_sel(mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr, ex_rs1_addr);
    assign fwd_b     = fwd_sel(mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr, ex_rs2_addr);
    assign halted    = (state == ST_HALTED);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_ecall_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt - 1'b1;
                    if (drain_cnt <= DRAIN_W'(1))
                        state <= ST_HALTED;
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // A flushed stage keeps its enable high so the bubble is actually captured.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if (state == ST_HALTED) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if ((state == ST_DRAIN) || run_halt || run_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (run_branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state != ST_HALTED),
        .count (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_branch),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use stall, branch flush,
// ecall drain/halt, async reset in DRAIN and counter saturation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [4:0] mem_rd_addr, wb_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_to_reg;
    logic       ex_branch_taken, ex_ecall_halt, mem_reg_write, wb_reg_write;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [1:0]  fwd_a, fwd_b, fsm_state;
    logic        halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
    logic        s_ex_mem_en, s_mem_wb_en, s_halted;
    logic [1:0]  s_fwd_a, s_fwd_b, s_fsm_state;
    logic [3:0]  s_cycle_cnt, s_stall_cnt, s_flush_cnt;

    int tests_run;
    int tests_failed;

    hazard_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch_taken(ex_branch_taken), .ex_ecall_halt(ex_ecall_halt),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .fsm_state(fsm_state),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch_taken(ex_branch_taken), .ex_ecall_halt(ex_ecall_halt),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted), .fsm_state(s_fsm_state),
        .cycle_cnt(s_cycle_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rs1_addr = 5'd0; ex_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
        ex_branch_taken = 1'b0; ex_ecall_halt = 1'b0;
        mem_rd_addr = 5'd0; mem_reg_write = 1'b0;
        wb_rd_addr = 5'd0; wb_reg_write = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = rd;
        id_rs2_addr = rd; id_rs2_used = 1'b1;
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        idle_inputs();
        rst = 1'b1;
        #3;
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_flush", flush_cnt, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        check("rst_enables", {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush},
              32'b1111100);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Forwarding
        mem_reg_write = 1'b1; mem_rd_addr = 5'd5; ex_rs1_addr = 5'd5; #1;
        check("fwd_a_mem", {30'd0, fwd_a}, 32'd1);
        wb_reg_write = 1'b1; wb_rd_addr = 5'd5; #1;
        check("fwd_a_mem_over_wb", {30'd0, fwd_a}, 32'd1);
        mem_reg_write = 1'b0; #1;
        check("fwd_a_wb", {30'd0, fwd_a}, 32'd2);
        wb_rd_addr = 5'd0; ex_rs1_addr = 5'd0; #1;
        check("fwd_a_x0", {30'd0, fwd_a}, 32'd0);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd0; #1;
        check("fwd_a_x0_mem", {30'd0, fwd_a}, 32'd0);
        idle_inputs();
        ex_rs2_addr = 5'd7; wb_rd_addr = 5'd7; wb_reg_write = 1'b1; ex_rs1_addr = 5'd7; #1;
        check("fwd_b_wb", {30'd0, fwd_b}, 32'd2);
        mem_rd_addr = 5'd7; #1;
        check("fwd_b_mem_no_we", {30'd0, fwd_b}, 32'd2);
        wb_reg_write = 1'b0; #1;
        check("fwd_b_none", {30'd0, fwd_b}, 32'd0);
        idle_inputs();

        // Load-use stall and non-hazard variants
        set_load_use(5'd6); id_rs2_used = 1'b0; #1;
        check("lu_unused_pc_en", {31'd0, pc_en}, 32'd1);
        set_load_use(5'd0); #1;
        check("lu_x0_pc_en", {31'd0, pc_en}, 32'd1);
        set_load_use(5'd6); #1;
        check("lu_ctrl", {27'd0, pc_en, if_id_en, id_ex_flush, id_ex_en, if_id_flush}, 32'b00110);
        tick();
        check("lu_stall_cnt", stall_cnt, 32'd1);
        idle_inputs();
        wb_rd_addr = 5'd6; wb_reg_write = 1'b1; ex_rs2_addr = 5'd6; #1;
        check("lu_after_fwd_b", {30'd0, fwd_b}, 32'd2);
        check("lu_after_en", {27'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}, 32'b11100);
        tick();
        check("lu_after_stall_cnt", stall_cnt, 32'd1);

        // Branch beats simultaneous load-use
        idle_inputs();
        set_load_use(5'd6); ex_branch_taken = 1'b1; #1;
        check("br_ctrl", {27'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}, 32'b11111);
        tick();
        check("br_flush_cnt", flush_cnt, 32'd1);
        check("br_stall_cnt", stall_cnt, 32'd1);
        idle_inputs();

        // Ecall drain then halt from a fresh reset (ecall in cycle 0)
        do_reset();
        ex_ecall_halt = 1'b1; #1;
        check("ec_run_ctrl", {28'd0, pc_en, if_id_en, id_ex_flush, ex_mem_en}, 32'b0011);
        tick();
        ex_ecall_halt = 1'b0; ex_branch_taken = 1'b1; set_load_use(5'd9); #1;
        check("ec_drain1_state", {30'd0, fsm_state}, 32'd1);
        check("ec_drain1_ctrl", {26'd0, pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en},
              32'b000111);
        tick();
        check("ec_drain2_state", {30'd0, fsm_state}, 32'd1);
        tick();
        check("ec_halted", {31'd0, halted}, 32'd1);
        check("ec_halt_ctrl", {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush},
              32'd0);
        check("ec_cycle", cycle_cnt, 32'd3);
        tick();
        tick();
        check("ec_cycle_frozen", cycle_cnt, 32'd3);
        check("ec_flush_ignored", flush_cnt, 32'd0);
        check("ec_stall_ignored", stall_cnt, 32'd0);
        idle_inputs();

        // Async reset while draining
        do_reset();
        ex_ecall_halt = 1'b1;
        tick();
        ex_ecall_halt = 1'b0;
        tick();
        check("ar_pre_state", {30'd0, fsm_state}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_state", {30'd0, fsm_state}, 32'd0);
        check("ar_halted", {31'd0, halted}, 32'd0);
        check("ar_cycle", cycle_cnt, 32'd0);
        check("ar_pc_en", {31'd0, pc_en}, 32'd1);
        rst = 1'b0;
        tick();

        // Saturation: 20 stall cycles on the 4-bit instance
        do_reset();
        set_load_use(5'd3);
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall_4b", {28'd0, s_stall_cnt}, 32'd15);
        check("sat_cycle_4b", {28'd0, s_cycle_cnt}, 32'd15);
        check("sat_stall_32b", stall_cnt, 32'd20);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage RV core. It drives the `en`/`flush` inputs of PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB, and generates the EX-stage operand forwarding selects.
- Detects load-use hazards and flushes on taken branches/jumps resolved in EXE.
- Runs a drain-then-halt sequence on a halting ecall.
- Keeps saturating performance counters for cycles, stalls and flushes.

Parameters:
- CNT_W, 32, width of each performance counter.
- DRAIN_CYCLES, 2, cycles after a halting ecall leaves EXE before all stages freeze (MEM + WB drain).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1_addr  in  5  rs1 of instruction in ID.
- id_rs2_addr  in  5  rs2 of instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rs1_addr  in  5  rs1 of instruction in EXE.
- ex_rs2_addr  in  5  rs2 of instruction in EXE.
- ex_rd_addr  in  5  rd of instruction in EXE.
- ex_reg_write  in  1  EXE instruction writes the register file.
- ex_mem_to_reg  in  1  EXE instruction is a load.
- ex_branch_taken  in  1  jal/jalr or a taken beq/bne resolved in EXE.
- ex_ecall_halt  in  1  EXE holds an ecall whose service is halt.
- mem_rd_addr  in  5  rd in MEM stage.
- mem_reg_write  in  1  MEM instruction writes the register file.
- wb_rd_addr  in  5  rd in WB stage.
- wb_reg_write  in  1  WB instruction writes the register file.
- pc_en  out  1  PC register enable.
- if_id_en  out  1  IF_ID enable.
- if_id_flush  out  1  IF_ID flush (bubble).
- id_ex_en  out  1  ID_EXE enable.
- id_ex_flush  out  1  ID_EXE flush (bubble).
- ex_mem_en  out  1  EXE_MEM enable.
- mem_wb_en  out  1  MEM_WB enable.
- fwd_a  out  2  EXE operand A source select.
- fwd_b  out  2  EXE operand B source select.
- halted  out  1  core frozen.
- cycle_cnt  out  CNT_W  non-halted cycles.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  branch flush cycles.

Behaviour:
- State machine RUN, DRAIN, HALTED; registered; async reset to RUN.
- Drain down-counter is DRAIN_CYCLES bits wide as needed (clog2); resets to 0.
- On reset:
  - Counters are 0 and halted=0.
  - All enables are 1 and flushes are 0, given idle inputs (outputs are combinational from state and inputs).
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately.
- Forwarding (combinational, every state):
  - fwd_a = 01 if mem_reg_write && mem_rd_addr!=0 && mem_rd_addr==ex_rs1_addr.
  - Otherwise 10 if the same test passes with wb_rd_addr/wb_reg_write.
  - Otherwise 00.
  - fwd_b is identical using ex_rs2_addr.
  - MEM beats WB. x0 is never forwarded.
- Load-use hazard is defined as: ex_mem_to_reg && ex_reg_write && ex_rd_addr!=0 && ((id_rs1_used && id_rs1_addr==ex_rd_addr) || (id_rs2_used && id_rs2_addr==ex_rd_addr)).
- RUN, priority order:
  - ex_ecall_halt: pc_en=0, if_id_en=0, id_ex_flush=1. Load DRAIN_CYCLES into the drain counter; next state DRAIN.
  - Else ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1. flush_cnt+1. Any simultaneous load-use is ignored because that instruction is wrong-path.
  - Else load-use: pc_en=0, if_id_en=0, id_ex_flush=1. stall_cnt+1. Exactly 1 bubble; the next cycle the hazard has cleared and forwarding 10 supplies the value.
  - Else all enables 1, flushes 0.
- DRAIN:
  - pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=1, mem_wb_en=1.
  - Decrement the drain counter; at 1, next state is HALTED.
  - Inputs ex_branch_taken, ex_ecall_halt and load-use are ignored.
- HALTED:
  - All enables 0, flushes 0, halted=1.
  - Terminal until rst.
- Flush dominates enable at the register: a stage with flush=1 also has en=1.
- Counters:
  - cycle_cnt increments every cycle the state is not HALTED.
  - All counters saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - State encoding ST_RUN, ST_DRAIN, ST_HALTED.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output count), instantiated three times.

Test Plan:
- Back-to-back ALU chain (add x5 in MEM, ex_rs1=5, mem_reg_write=1) -> fwd_a=01. Same rd in WB only -> fwd_a=10. rd=0 -> fwd_a=00.
- Load x6 in EXE (ex_mem_to_reg=1) with ID rs2=6 used -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. stall_cnt goes 0->1. Next cycle all enables 1.
- ex_branch_taken=1 together with a load-use condition -> if_id_flush=1, id_ex_flush=1, pc_en=1. flush_cnt=1, stall_cnt unchanged.
- ex_ecall_halt pulse at cycle N -> DRAIN for cycles N+1, N+2 with ex_mem_en=1. From N+3, halted=1, all enables 0, and cycle_cnt frozen at N+3.
- rst asserted asynchronously while in DRAIN -> state RUN, counters 0 and halted=0 before the next clock edge.
- CNT_W=4, load-use held for 20 cycles -> stall_cnt saturates at 15.
